// File: rtl/segment_stream_pkg.sv
// Shared types and default widths for the segment_stream datapath sequencer.
package segment_stream_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } seqState_t;

endpackage

// File: rtl/segment_stream_sequencer_axis_reg_slice.sv
// One-entry AXI4-Stream output register carrying tdata and tlast.
module segment_stream_sequencer_axis_reg_slice #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              load,
  input  logic [DATA_W-1:0] inData,
  input  logic              inLast,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  output logic              outLast
);

  // load is only raised when the slot is empty or draining this cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      outData  <= '0;
      outLast  <= 1'b0;
      outValid <= 1'b0;
    end else if (load) begin
      outData  <= inData;
      outLast  <= inLast;
      outValid <= 1'b1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: rtl/segment_stream_sequencer.sv
// Cuts a continuous sample stream into TLAST-delimited AXI4-Stream segments,
// for a fixed number of segments or continuously until aborted.
module segment_stream_sequencer
  import segment_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LEN_W-1:0]  cfg_seg_len,
  input  logic [CNT_W-1:0]  cfg_num_seg,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_err,
  output logic [CNT_W-1:0]  sts_seg_count,
  output logic              seg_irq
);

  seqState_t        state, nextState;
  logic [LEN_W-1:0] segLen, beatCnt;
  logic [CNT_W-1:0] numSeg, segLoaded;
  logic             abortPend;
  logic             load, lastBeat, limitHit, abortAny, startOk, mHandshake;

  assign load       = s_axis_tvalid & s_axis_tready;
  assign lastBeat   = (beatCnt == LEN_W'(segLen - 1'b1));
  assign limitHit   = (numSeg != '0) && (CNT_W'(segLoaded + 1'b1) == numSeg);
  assign abortAny   = abortPend | cfg_abort;
  assign startOk    = cfg_start & (cfg_seg_len != '0);
  assign mHandshake = m_axis_tvalid & m_axis_tready;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= nextState;
  end

  // Next state: RUN ends on the final TLAST load, or at once if aborted on a segment boundary
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (startOk) nextState = RUN;
      RUN: begin
        if (load && lastBeat && (limitHit || abortAny))     nextState = STOP;
        else if (abortAny && !load && (beatCnt == '0))      nextState = STOP;
      end
      STOP: if (!m_axis_tvalid || m_axis_tready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    s_axis_tready = 1'b0;
    sts_busy      = 1'b0;
    unique case (state)
      RUN: begin
        s_axis_tready = ~m_axis_tvalid | m_axis_tready;
        sts_busy      = 1'b1;
      end
      STOP:    sts_busy = 1'b1;
      default: ;
    endcase
  end

  // Run configuration, beat/segment counters and sticky status
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      segLen        <= '0;
      numSeg        <= '0;
      beatCnt       <= '0;
      segLoaded     <= '0;
      abortPend     <= 1'b0;
      sts_done      <= 1'b0;
      sts_err       <= 1'b0;
      sts_seg_count <= '0;
      seg_irq       <= 1'b0;
    end else begin
      seg_irq <= mHandshake & m_axis_tlast;
      if (mHandshake && m_axis_tlast) sts_seg_count <= sts_seg_count + 1'b1;
      if ((state == RUN) && cfg_abort) abortPend <= 1'b1;
      if (load) begin
        if (lastBeat) begin
          beatCnt   <= '0;
          segLoaded <= segLoaded + 1'b1;
        end else begin
          beatCnt   <= beatCnt + 1'b1;
        end
      end
      if ((state == STOP) && (nextState == IDLE)) sts_done <= 1'b1;
      if ((state == IDLE) && cfg_start) begin
        if (startOk) begin
          segLen        <= cfg_seg_len;
          numSeg        <= cfg_num_seg;
          beatCnt       <= '0;
          segLoaded     <= '0;
          abortPend     <= 1'b0;
          sts_done      <= 1'b0;
          sts_err       <= 1'b0;
          sts_seg_count <= '0;
        end else begin
          sts_err <= 1'b1;
        end
      end
    end
  end

  segment_stream_sequencer_axis_reg_slice #(
    .DATA_W (DATA_W)
  ) u_outReg (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .load     (load),
    .inData   (s_axis_tdata),
    .inLast   (lastBeat),
    .outReady (m_axis_tready),
    .outData  (m_axis_tdata),
    .outValid (m_axis_tvalid),
    .outLast  (m_axis_tlast)
  );

endmodule
